// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants
// and the odd-parity helper used by the host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } ps2_state_e;

  localparam int INHIBIT_CYCLES_DEF = 2048;
  localparam int FILTER_CYCLES_DEF  = 8;
  localparam int TIMEOUT_CYCLES_DEF = 32768;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line; emits the
// filtered level and one-cycle fall/rise events. Shared with the PS/2 receiver.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic LINE_IN,
  output logic SYNC,
  output logic LEVEL,
  output logic FALL,
  output logic RISE
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             fall_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize the line and flip the filtered level once it has disagreed long enough
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      fall_r  <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= CNT_W'(0);
    end else begin
      sync1_r <= LINE_IN;
      sync2_r <= sync1_r;
      fall_r  <= 1'b0;
      rise_r  <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_W'(0);
      end else if (cnt_r == CNT_W'(FILTER_CYCLES - 1)) begin
        level_r <= sync2_r;
        fall_r  <= ~sync2_r;
        rise_r  <= sync2_r;
        cnt_r   <= CNT_W'(0);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign SYNC  = sync2_r;
  assign LEVEL = level_r;
  assign FALL  = fall_r;
  assign RISE  = rise_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain KB_CLK/KB_DATA
// through output enables. Define PS2_TX_TIMEOUT_EN to add the inter-edge watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int FILTER_CYCLES  = FILTER_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_state_e       state_r;
  logic [7:0]       data_r;
  logic             parity_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic             err_r;
  logic             busy_r;
  logic             done_r;
  logic             err_pulse_r;
  logic             clk_oe_r;
  logic             data_oe_r;

  logic clk_sync_s, clk_level_s, clk_fall_s, clk_rise_s;
  logic data_sync_s, data_level_s, data_fall_s, data_rise_s;
  logic timeout_s;
  logic unused_edges_s;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .CLK(CLK), .RST(RST), .LINE_IN(KB_CLK_IN),
    .SYNC(clk_sync_s), .LEVEL(clk_level_s), .FALL(clk_fall_s), .RISE(clk_rise_s)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .CLK(CLK), .RST(RST), .LINE_IN(KB_DATA_IN),
    .SYNC(data_sync_s), .LEVEL(data_level_s), .FALL(data_fall_s), .RISE(data_rise_s)
  );

  assign unused_edges_s = ^{clk_sync_s, clk_rise_s, data_fall_s, data_rise_s};

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_r;
  logic            wd_active_s;

  assign wd_active_s = (state_r == ST_SEND) || (state_r == ST_ACK) || (state_r == ST_WAITIDLE);
  assign timeout_s   = wd_active_s && (wdog_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on SEND entry and on every accepted clock edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_r <= WD_W'(0);
    end else if ((state_r == ST_REQ) || clk_fall_s || clk_rise_s) begin
      wdog_r <= WD_W'(0);
    end else if (wd_active_s) begin
      wdog_r <= wdog_r + WD_W'(1);
    end else begin
      wdog_r <= WD_W'(0);
    end
  end
`else
  localparam int unused_timeout_c = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // Transaction sequencer with registered line enables and status pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      data_r      <= 8'h00;
      parity_r    <= 1'b0;
      bit_cnt_r   <= 4'd0;
      inh_cnt_r   <= INH_W'(0);
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_pulse_r <= 1'b0;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      err_pulse_r <= 1'b0;
      if (timeout_s) begin
        state_r     <= ST_IDLE;
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
        err_pulse_r <= 1'b1;
        clk_oe_r    <= 1'b0;
        data_oe_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (TX_START) begin
              data_r    <= TX_DATA;
              parity_r  <= odd_parity(TX_DATA);
              bit_cnt_r <= 4'd0;
              inh_cnt_r <= INH_W'(0);
              err_r     <= 1'b0;
              busy_r    <= 1'b1;
              clk_oe_r  <= 1'b1;
              state_r   <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt_r == INH_W'(INHIBIT_CYCLES - 1)) begin
              data_oe_r <= 1'b1;
              state_r   <= ST_REQ;
            end else begin
              inh_cnt_r <= inh_cnt_r + INH_W'(1);
            end
          end
          ST_REQ: begin
            clk_oe_r <= 1'b0;
            state_r  <= ST_SEND;
          end
          ST_SEND: begin
            // Falls 1..8 carry data LSB first, 9 parity, 10 the released stop bit
            if (clk_fall_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r < 4'd8) begin
                data_oe_r <= ~data_r[bit_cnt_r[2:0]];
              end else if (bit_cnt_r == 4'd8) begin
                data_oe_r <= ~parity_r;
              end else begin
                data_oe_r <= 1'b0;
                state_r   <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            if (clk_fall_s) begin
              err_r   <= data_sync_s;
              state_r <= ST_WAITIDLE;
            end
          end
          ST_WAITIDLE: begin
            if (clk_level_s && data_level_s) begin
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              err_pulse_r <= err_r;
              state_r     <= ST_IDLE;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TX_BUSY    = busy_r;
  assign TX_DONE    = done_r;
  assign TX_ERR     = err_pulse_r;
  assign KB_CLK_OE  = clk_oe_r;
  assign KB_DATA_OE = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a keyboard model clocks frames out of the
// host over wired-AND lines and compares them with a frame model built from the byte.
module tb_ps2_host_tx;

  localparam int HALF = 64;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       kb_clk_oe, kb_data_oe;
  logic       dev_clk, dev_data;
  logic       kb_clk_in, kb_data_in;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;

  assign kb_clk_in  = ~kb_clk_oe & dev_clk;
  assign kb_data_in = ~kb_data_oe & dev_data;

  ps2_host_tx dut (
    .CLK(CLK), .RST(RST), .TX_DATA(tx_data), .TX_START(tx_start),
    .TX_BUSY(tx_busy), .TX_DONE(tx_done), .TX_ERR(tx_err),
    .KB_CLK_IN(kb_clk_in), .KB_DATA_IN(kb_data_in),
    .KB_CLK_OE(kb_clk_oe), .KB_DATA_OE(kb_data_oe)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (tx_done === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame as the device sees it: start, data LSB first, odd parity, stop
  function automatic bit [10:0] frame(input logic [7:0] d);
    int ones = 0;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame[i + 1] = d[i];
      ones += int'(d[i]);
    end
    frame[9]  = (ones % 2 == 0);
    frame[10] = 1'b1;
  endfunction

  task automatic pulse_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Full host transaction against the device model; abort_k>0 resets after that edge
  task automatic xfer(input string tag, input logic [7:0] d, input bit nack,
                      input bit repulse, input int abort_k);
    bit [10:0] seen;
    int low_cnt;
    int t;
    int d0;
    seen = '0;
    d0   = done_cnt;
    pulse_start(d);
    check({tag, " busy_on_start"}, tx_busy, 1);
    low_cnt = 0;
    while (kb_clk_oe === 1'b1 && low_cnt < 5000) begin
      low_cnt++;
      if (repulse && low_cnt == 100) begin tx_start = 1'b1; tx_data = 8'h55; end
      if (repulse && low_cnt == 101) tx_start = 1'b0;
      tick(1);
    end
    check({tag, " clk_oe_cycles"}, low_cnt, 2049);
    check({tag, " start_bit_oe"}, kb_data_oe, 1);
    seen[0] = kb_data_in;
    tick(40);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && !nack) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (repulse && k == 3) begin tx_start = 1'b1; tx_data = 8'h55; end
      tick(1);
      tx_start = 1'b0;
      tick(HALF - 1);
      if (k <= 10) seen[k] = kb_data_in;
      dev_clk = 1'b1;
      if (k == 11) begin
        dev_data = 1'b1;
      end else begin
        tick(HALF);
      end
      if (k == abort_k) begin
        RST = 1'b1;
        tick(1);
        check({tag, " rst_clk_oe"}, kb_clk_oe, 0);
        check({tag, " rst_data_oe"}, kb_data_oe, 0);
        check({tag, " rst_busy"}, tx_busy, 0);
        RST = 1'b0;
        tick(100);
        check({tag, " rst_no_done"}, done_cnt - d0, 0);
        return;
      end
    end
    t = 0;
    while (tx_done !== 1'b1 && t < 2000) begin
      tick(1);
      t++;
    end
    check({tag, " done"}, tx_done, 1);
    check({tag, " err"}, tx_err, nack);
    check({tag, " busy_at_done"}, tx_busy, 0);
    check({tag, " oe_at_done"}, {kb_clk_oe, kb_data_oe}, 0);
    tick(1);
    check({tag, " done_one_cycle"}, tx_done, 0);
    tick(50);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " frame_bits"}, seen, frame(d));
  endtask

  initial begin
    int t;
    int d0;
    logic [7:0] rb;
    bit rn;
    RST      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick(3);
    check("reset_outputs", {tx_busy, tx_done, tx_err, kb_clk_oe, kb_data_oe}, 0);
    RST = 1'b0;
    tick(2);
    check("idle_outputs", {tx_busy, tx_done, tx_err, kb_clk_oe, kb_data_oe}, 0);

    check("model_ed", frame(8'hED), 11'b11_1110_1101_0);

    xfer("ed_ack", 8'hED, 1'b0, 1'b0, 0);
    xfer("x01", 8'h01, 1'b0, 1'b0, 0);
    xfer("xff", 8'hFF, 1'b0, 1'b0, 0);
    xfer("nack", 8'hED, 1'b1, 1'b0, 0);
    xfer("restart_f4", 8'hF4, 1'b0, 1'b1, 0);
    xfer("reset_mid", 8'hA5, 1'b0, 1'b0, 5);
    xfer("after_rst_ff", 8'hFF, 1'b0, 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      rn = 1'($urandom_range(0, 1));
      xfer("random", rb, rn, 1'b0, 0);
    end

    // Device that never clocks after the request
    d0 = done_cnt;
    pulse_start(8'h12);
    t = 0;
    while (kb_clk_oe === 1'b1 && t < 5000) begin tick(1); t++; end
`ifdef PS2_TX_TIMEOUT_EN
    t = 0;
    while (tx_done !== 1'b1 && t < 40000) begin tick(1); t++; end
    check("timeout_done", tx_done, 1);
    check("timeout_err", tx_err, 1);
    check("timeout_oe", {kb_clk_oe, kb_data_oe}, 0);
    check("timeout_busy", tx_busy, 0);
`else
    tick(3000);
    check("hang_busy", tx_busy, 1);
    check("hang_no_done", done_cnt - d0, 0);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("hang_recover", {tx_busy, kb_clk_oe, kb_data_oe}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter for the keyboard port in the CPLD.
- Sends one command byte per request to the attached keyboard (LED set 0xED, reset 0xFF, and so on) using the host-to-device PS/2 sequence: request-to-send, 8 data bits LSB first, odd parity, stop, then device ACK.
- Drives the open-drain KB_CLK/KB_DATA lines through output-enable pins alongside the existing PS/2 receiver.
- While TX_BUSY is high, the receiver ignores the lines.

## Interface
- INHIBIT_CYCLES, 2048: CLK cycles KB_CLK is held low for request-to-send (≥100 µs at 18.432 MHz).
- FILTER_CYCLES, 8: cycles the synchronized KB_CLK must be stable low/high before an edge is accepted.
- TIMEOUT_CYCLES, 32768: watchdog limit between accepted edges (used only with PS2_TX_TIMEOUT_EN).
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- TX_DATA  in  8  byte to send; latched when TX_START is accepted.
- TX_START  in  1  request strobe; accepted only when TX_BUSY=0.
- TX_BUSY  out  1  high from acceptance until return to IDLE.
- TX_DONE  out  1  one-cycle pulse when the transaction ends, whether it succeeded or failed.
- TX_ERR  out  1  one-cycle pulse coincident with TX_DONE on NACK or timeout.
- KB_CLK_IN  in  1  raw PS/2 clock line.
- KB_DATA_IN  in  1  raw PS/2 data line.
- KB_CLK_OE  out  1  1 = pull PS/2 clock low.
- KB_DATA_OE  out  1  1 = pull PS/2 data low.

## Operation
- Reset values: all outputs 0, state IDLE, bit counter 0, latched byte 0x00.
- **IDLE**: TX_START=1 → latch TX_DATA and compute parity = ~^TX_DATA → go to INHIBIT.
- **INHIBIT**: KB_CLK_OE=1 for INHIBIT_CYCLES cycles → go to REQ.
- **REQ**: KB_CLK_OE=1 and KB_DATA_OE=1 for exactly one cycle (start bit asserted) → go to SEND.
- **SEND**: KB_CLK_OE=0; KB_DATA_OE remains 1 until the first falling edge.
  - On each accepted KB_CLK falling edge k (k = 1..10): KB_DATA_OE = ~bit.
  - k=1..8 sends data bits 0..7; k=9 sends parity; k=10 sends stop (KB_DATA_OE=0).
  - After k=10 → go to ACK.
- **ACK**: on the next accepted falling edge (k=11), sample the synchronized KB_DATA.
  - 0 = ACK; 1 = NACK, and the error flag is recorded.
  - Then go to WAITIDLE.
- **WAITIDLE**: wait until synchronized KB_CLK and KB_DATA are both high for FILTER_CYCLES → pulse TX_DONE (and TX_ERR if flagged) → go to IDLE.
- Edge detection:
  - 2-FF synchronizer on both lines.
  - A falling edge is accepted after FILTER_CYCLES consecutive low samples following a filtered-high level. Rising edges are filtered the same way.
  - Edges are ignored in IDLE, INHIBIT and REQ.
- TX_START while busy: ignored, no queuing. TX_DATA changes after acceptance have no effect.
- RST mid-transaction: the next cycle has both OEs=0, IDLE, and no TX_DONE pulse. The bus is released and the device times out on its own.

## Timing
- TX_START high at edge N in IDLE → TX_BUSY=1 and KB_CLK_OE=1 from N+1.
- KB_CLK_OE high for INHIBIT_CYCLES+1 cycles total (INHIBIT plus REQ). KB_DATA_OE rises one cycle before KB_CLK_OE falls.
- Physical KB_CLK fall → accepted edge after 2+FILTER_CYCLES cycles → KB_DATA_OE updates on the following cycle. This is well inside the ~40 µs low phase.
- TX_DONE/TX_ERR pulse one cycle; TX_BUSY falls in the same cycle as TX_DONE.
- Next TX_START is accepted no earlier than the cycle after TX_DONE.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A watchdog counter resets on entry to SEND and on every accepted edge.
  - If it reaches TIMEOUT_CYCLES in SEND, ACK or WAITIDLE: both OEs=0, and TX_DONE and TX_ERR pulse in the same cycle → go to IDLE.
- Undefined: no counter. The FSM waits indefinitely; only RST recovers a hung device.

## Structure
- Shared package ps2_pkg: state encoding (IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE), odd-parity function, default INHIBIT_CYCLES/FILTER_CYCLES constants.
- Sub-module ps2_line_filter: synchronizer, stability filter, fall/rise event outputs. The receiver is to reuse it.

## Test plan
- Send 0xED, device model clocks at 12 kHz and ACKs:
  - KB_CLK_OE low period = 2049 cycles.
  - Bits seen at device rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - TX_DONE=1, TX_ERR=0.
- Send 0x01 → parity bit 0; send 0xFF → parity bit 1. Both complete with TX_ERR=0.
- Device holds KB_DATA high at edge 11 (NACK) → TX_DONE and TX_ERR pulse together after the lines idle.
- TX_START re-pulsed with 0x55 during a 0xF4 transfer → the 0xF4 bits are unchanged and only one TX_DONE occurs.
- RST asserted after edge 5 → next cycle KB_CLK_OE=0, KB_DATA_OE=0, TX_BUSY=0, no TX_DONE. A following 0xFF transfer succeeds.
- With PS2_TX_TIMEOUT_EN, device never clocks after REQ → after 32768 cycles TX_DONE and TX_ERR pulse and both OEs=0. Without the macro, TX_BUSY stays 1.
